// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter for a shared register bank, with locked
// (atomic) ownership sequences and registered bank strobes / read return.
module reg_bank_arbiter #(
  parameter int N_REGS = 8,
  parameter int AW     = $clog2(N_REGS),
  parameter int DW     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic              LOCK0,
  input  logic              LOCK1,
  input  logic [AW-1:0]     ADDR0,
  input  logic [AW-1:0]     ADDR1,
  input  logic [DW-1:0]     WDATA0,
  input  logic [DW-1:0]     WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DW-1:0]     RDATA,
  output logic [N_REGS-1:0] CS,
  output logic              W,
  output logic              R,
  output logic [DW-1:0]     D,
  input  logic [DW-1:0]     Q
);

  // Handshake: REQx (with WEx/LOCKx/ADDRx/WDATAx) is held until GNTx is seen;
  // GNTx is a one-cycle pulse marking the access as taken, and RVALIDx pulses
  // one cycle later with RDATA for reads.
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state;
  logic   ptr;

  logic              grant_any;
  logic              win;
  logic              we_w;
  logic              lock_w;
  logic [AW-1:0]     addr_w;
  logic [DW-1:0]     wdata_w;
  logic [N_REGS-1:0] cs_next;

  always_comb begin
    grant_any = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (REQ0 && REQ1) begin
          grant_any = 1'b1;
          win       = ptr;
        end else if (REQ0) begin
          grant_any = 1'b1;
        end else if (REQ1) begin
          grant_any = 1'b1;
          win       = 1'b1;
        end
      end
      OWN0: grant_any = REQ0;
      OWN1: begin
        grant_any = REQ1;
        win       = 1'b1;
      end
      default: grant_any = 1'b0;
    endcase
    we_w    = win ? WE1 : WE0;
    lock_w  = win ? LOCK1 : LOCK0;
    addr_w  = win ? ADDR1 : ADDR0;
    wdata_w = win ? WDATA1 : WDATA0;
    // Out-of-range addresses still get a grant but select no cell.
    cs_next = '0;
    if (int'(addr_w) < N_REGS) cs_next = N_REGS'(1) << addr_w;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA   <= '0;
      CS      <= '0;
      W       <= 1'b0;
      R       <= 1'b0;
      D       <= '0;
    end else begin
      // Return side of the access issued on the previous edge.
      RVALID0 <= R && GNT0;
      RVALID1 <= R && GNT1;
      if (R) RDATA <= (|CS) ? Q : '0;

      GNT0 <= grant_any && !win;
      GNT1 <= grant_any && win;
      CS   <= grant_any ? cs_next : '0;
      W    <= grant_any && we_w;
      R    <= grant_any && !we_w;
      if (grant_any && we_w) D <= wdata_w;

      case (state)
        IDLE: begin
          if (REQ0 && REQ1) ptr <= ~ptr;
          if (grant_any && lock_w) state <= win ? OWN1 : OWN0;
        end
        OWN0: if (!(REQ0 && LOCK0)) begin
          state <= IDLE;
          ptr   <= 1'b1;
        end
        OWN1: if (!(REQ1 && LOCK1)) begin
          state <= IDLE;
          ptr   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of N_REGS 16-bit register cells between two requesters: requester 0 is the execute unit, requester 1 is load/store or debug.
- The bank has one shared D bus, one shared OUT bus, per-register CS, and common W and R strobes.
- The block arbitrates round-robin, supports locked (atomic) sequences, and drives the bank strobes.
- It returns registered read data to the winning requester, one access per cycle at full throughput.

Parameters:
- N_REGS, 8, number of registers in the bank.
- AW, 3, address width; clog2(N_REGS).
- DW, 16, data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- REQ0, REQ1  in  1  access request, held until GNTx is seen.
- WE0, WE1  in  1  1 = write, 0 = read; held with REQx.
- LOCK0, LOCK1  in  1  keep ownership after this access.
- ADDR0, ADDR1  in  AW  register index.
- WDATA0, WDATA1  in  DW  write data.
- GNT0, GNT1  out  1  one-cycle pulse: this cycle's access belongs to requester x.
- RVALID0, RVALID1  out  1  read data valid for requester x.
- RDATA  out  DW  registered read data, shared by both requesters.
- CS  out  N_REGS  one-hot bank chip select.
- W  out  1  bank write strobe.
- R  out  1  bank read strobe.
- D  out  DW  bank write data.
- Q  in  DW  bank OUT bus; valid only while R and CS are asserted.

Behaviour:
- Reset values (asynchronous, immediate): GNT0/1=0, RVALID0/1=0, RDATA=0, CS=0, W=0, R=0, D=0, state=IDLE, priority pointer=0.
- Reset during an access drops W immediately; a write in flight does not commit.
- All outputs come from registers; there is no combinational path from the REQ inputs to the outputs.
- FSM states: IDLE, OWN0, OWN1, all evaluated at each rising edge.
  - IDLE, single request x → grant x.
  - IDLE, both requesting → grant the requester named by the priority pointer; the pointer then flips to the loser.
  - IDLE, a grant with LOCKx=1 → next state OWNx.
  - OWNx, REQx with LOCKx=1 → grant x, stay in OWNx; the other requester is starved.
  - OWNx, REQx with LOCKx=0 → grant x, then go to IDLE; the pointer moves to the other requester.
  - OWNx, REQx=0 → go to IDLE with no grant; the pointer moves to the other requester.
- Grant edge k (access sampled from the winner's inputs):
  - GNTx=1, CS=onehot(ADDRx).
  - Write: W=WE, D=WDATA.
  - Read: R=~WE.
  - All of these stay high for exactly cycle k..k+1.
- Edge k+1:
  - A write commits into the bank.
  - A read captures Q into RDATA; RVALIDx=1 for cycle k+1..k+2; RDATA holds its value until the next read.
- Back-to-back accesses: a new grant may issue at edge k+1 with no bubble; W/R/CS stay asserted continuously while grants continue.
- Read-after-write to the same register in consecutive grants returns the newly written value, because the write commits before the read's Q is sampled.
- A requester that still has REQ high in the cycle after its GNT is a new request.
- ADDR >= N_REGS: GNT is issued, CS=0, no bank effect; a read returns RDATA=0 with RVALID=1.
- GNT0 and GNT1 are never high in the same cycle. Neither are RVALID0 and RVALID1.

Test Plan:
- Reset: assert RST mid-write (REQ0=1, WE0=1, ADDR0=2, WDATA0=325) → W, CS, GNT0 go low immediately; a later read of R2 returns its pre-reset contents.
- Single requester: write 724 to R5, then read R5 → GNT0 pulses on both accesses; RDATA=724 with RVALID0=1 one cycle after the read grant.
- Contention: REQ0 and REQ1 both held for 4 accesses from reset → grants alternate 0,1,0,1; R1 and R3 hold the values written.
- Lock: REQ1 with LOCK1=1 for 3 accesses while REQ0 is held → GNT1 ×3, then GNT0 on the access after LOCK1 drops.
- Hazard: write 4362 to R7 at grant k, read R7 at grant k+1 → RDATA=4362 at k+2.
- Out of range (N_REGS=6): read address 7 → CS=0, RDATA=0, RVALID=1.
